// File: rtl/hdmi_filter_pkg.sv
// Shared encodings and defaults for the HDMI filter mode controller.
// The mode and state enums are used by the controller RTL.
package hdmi_filter_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS  = 2'd0,
      MODE_G3      = 2'd1,
      MODE_G5      = 2'd2,
      MODE_ILLEGAL = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PEND   = 2'd1,
      ST_CLEAR  = 2'd2,
      ST_WARMUP = 2'd3
   } state_e;

   localparam int WARMUP_G3_DEF = 2;
   localparam int WARMUP_G5_DEF = 4;
   localparam int LINE_CNT_W    = 8;

   // Auto-cycle order: bypass -> 3x3 -> 5x5 -> bypass.
   function automatic mode_e next_mode(input mode_e m);
      case (m)
         MODE_BYPASS: return MODE_G3;
         MODE_G3:     return MODE_G5;
         default:     return MODE_BYPASS;
      endcase
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers a timing strobe once and reports its rising and falling edges
// relative to the registered copy.
module sync_edge_det (
   input  logic pix_clk,
   input  logic rst,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic sig_d;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge pix_clk) begin
      if (rst) sig_d <= 1'b0;
      else     sig_d <= sig;
   end

   assign rise = sig & ~sig_d;
   assign fall = ~sig & sig_d;

endmodule

// File: rtl/hdmi_filter_mode_ctrl.sv
// Frame-synchronous filter mode controller: commits mode requests on vsync
// rising edges, then clears the line buffers and blanks output during warm-up.
module hdmi_filter_mode_ctrl
   import hdmi_filter_pkg::*;
#(
   parameter int          WARMUP_G3  = WARMUP_G3_DEF,
   parameter int          WARMUP_G5  = WARMUP_G5_DEF,
   parameter logic [15:0] FRAME_HOLD = 16'd120
) (
   input  logic       pix_clk,
   input  logic       rst,
   input  logic       vs_in,
   input  logic       de_in,
   input  logic       req_valid,
   input  logic [1:0] req_mode,
   output logic       req_ready,
   input  logic       auto_en,
   output logic [1:0] mode_out,
   output logic       filter_en,
   output logic       lb_clr,
   output logic       out_blank,
   output logic       req_err,
   output logic       busy
);

   localparam logic [15:0]           FRAME_LAST = FRAME_HOLD - 16'd1;
   localparam logic [LINE_CNT_W-1:0] LINES_G3   = LINE_CNT_W'(WARMUP_G3);
   localparam logic [LINE_CNT_W-1:0] LINES_G5   = LINE_CNT_W'(WARMUP_G5);
   localparam logic [LINE_CNT_W-1:0] LINE_ONE   = LINE_CNT_W'(1);

   state_e                  state, state_nxt;
   mode_e                   mode_q, pend_mode;
   logic [15:0]             frame_cnt;
   logic [LINE_CNT_W-1:0]   line_cnt;
   logic                    vs_rise, vs_fall, de_rise, line_end;
   logic                    accept, auto_hit, frame_wrap;
   logic                    unused_edges;

   sync_edge_det u_vs_edge (
      .pix_clk (pix_clk),
      .rst     (rst),
      .sig     (vs_in),
      .rise    (vs_rise),
      .fall    (vs_fall)
   );

   sync_edge_det u_de_edge (
      .pix_clk (pix_clk),
      .rst     (rst),
      .sig     (de_in),
      .rise    (de_rise),
      .fall    (line_end)
   );

   assign unused_edges = vs_fall | de_rise;

   assign accept     = (state == ST_RUN) && req_valid;
   assign frame_wrap = (frame_cnt == FRAME_LAST);
   // A manual request in the same cycle wins; the auto event is simply dropped.
   assign auto_hit   = (state == ST_RUN) && auto_en && vs_rise && frame_wrap;

   always_ff @(posedge pix_clk) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:    if (accept || auto_hit) state_nxt = ST_PEND;
         ST_PEND:   if (vs_rise) state_nxt = ST_CLEAR;
         ST_CLEAR:  state_nxt = (pend_mode == MODE_BYPASS) ? ST_RUN : ST_WARMUP;
         ST_WARMUP: if (line_end && (line_cnt == LINE_ONE)) state_nxt = ST_RUN;
         default:   state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      req_ready = (state == ST_RUN);
      lb_clr    = (state == ST_CLEAR);
      out_blank = (state == ST_CLEAR) || (state == ST_WARMUP);
      busy      = (state != ST_RUN);
   end

   always_ff @(posedge pix_clk) begin
      if (rst) begin
         pend_mode <= MODE_BYPASS;
         mode_q    <= MODE_BYPASS;
         filter_en <= 1'b0;
         req_err   <= 1'b0;
         frame_cnt <= '0;
         line_cnt  <= '0;
      end else begin
         req_err <= accept && (req_mode == MODE_ILLEGAL);

         if (accept)
            pend_mode <= (req_mode == MODE_ILLEGAL) ? MODE_BYPASS : mode_e'(req_mode);
         else if (auto_hit)
            pend_mode <= next_mode(mode_q);

         // Mode and enable change together on the cycle CLEAR begins.
         if ((state == ST_PEND) && vs_rise) begin
            mode_q    <= pend_mode;
            filter_en <= (pend_mode != MODE_BYPASS);
         end

         if (state == ST_CLEAR)
            frame_cnt <= '0;
         else if (vs_rise)
            frame_cnt <= frame_wrap ? 16'd0 : frame_cnt + 16'd1;

         if (state == ST_CLEAR) begin
            if (pend_mode == MODE_G3)      line_cnt <= LINES_G3;
            else if (pend_mode == MODE_G5) line_cnt <= LINES_G5;
         end else if ((state == ST_WARMUP) && line_end) begin
            line_cnt <= line_cnt - LINE_ONE;
         end
      end
   end

   assign mode_out = mode_q;

endmodule

// File: tb/tb_hdmi_filter_mode_ctrl.sv
// Randomised bench for hdmi_filter_mode_ctrl: a behavioural model predicts
// every cycle's outputs and each commit; a monitor compares them off-edge.
module tb_hdmi_filter_mode_ctrl;

   localparam int FH = 2;
   localparam int G3 = 2;
   localparam int G5 = 4;

   logic       pix_clk = 1'b0;
   logic       rst = 1'b1, vs_in = 1'b0, de_in = 1'b0;
   logic       req_valid = 1'b0, auto_en = 1'b0;
   logic [1:0] req_mode = 2'd0;
   logic       req_ready, filter_en, lb_clr, out_blank, req_err, busy;
   logic [1:0] mode_out;

   hdmi_filter_mode_ctrl #(
      .WARMUP_G3  (G3),
      .WARMUP_G5  (G5),
      .FRAME_HOLD (16'(FH))
   ) dut (
      .pix_clk   (pix_clk),
      .rst       (rst),
      .vs_in     (vs_in),
      .de_in     (de_in),
      .req_valid (req_valid),
      .req_mode  (req_mode),
      .req_ready (req_ready),
      .auto_en   (auto_en),
      .mode_out  (mode_out),
      .filter_en (filter_en),
      .lb_clr    (lb_clr),
      .out_blank (out_blank),
      .req_err   (req_err),
      .busy      (busy)
   );

   always #5 pix_clk = ~pix_clk;

   typedef struct packed {
      logic [7:0]  outs;   // {mode, filter_en, lb_clr, out_blank, req_err, busy, req_ready}
      logic [15:0] frames;
   } exp_t;

   exp_t exp_q[$];
   int   commit_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   // Reference model: pending request (-1 none), one-cycle clear flag,
   // lines of warm-up still to go, committed mode, frames since last commit.
   bit m_vs_d, m_de_d, m_clear, m_err;
   int m_pending = -1, m_warm = 0, m_mode = 0, m_frames = 0;

   // Stimulus knobs.
   int req_pct = 0, shot_mode = -1;
   bit ae = 0, collide = 0, rst_g5_shot = 0, drop_ae_in_pend = 0;
   bit rand_edges = 0, rand_rst = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit model_busy();
      return (m_pending >= 0) || m_clear || (m_warm > 0);
   endfunction

   function automatic void model_step(input bit vs, de, rv, input int rm, input bit aen, r);
      bit vs_rise, line_end, auto_hit, err_n;
      if (r) begin
         m_vs_d = 0; m_de_d = 0; m_clear = 0; m_err = 0;
         m_pending = -1; m_warm = 0; m_mode = 0; m_frames = 0;
         return;
      end
      vs_rise  = vs && !m_vs_d;
      line_end = m_de_d && !de;
      err_n    = 0;
      if (m_clear) begin
         m_clear  = 0;
         m_frames = 0;
         if (m_mode != 0) m_warm = (m_mode == 1) ? G3 : G5;
         m_pending = -1;
      end else if (m_warm > 0) begin
         if (vs_rise) m_frames = (m_frames + 1) % FH;
         if (line_end) m_warm--;
      end else if (m_pending >= 0) begin
         if (vs_rise) begin
            m_frames = (m_frames + 1) % FH;
            m_clear  = 1;
            m_mode   = m_pending;
            commit_q.push_back(m_pending);
         end
      end else begin
         auto_hit = aen && vs_rise && (m_frames == FH - 1);
         if (vs_rise) m_frames = (m_frames + 1) % FH;
         if (rv) begin
            m_pending = (rm == 3) ? 0 : rm;
            err_n     = (rm == 3);
         end else if (auto_hit) begin
            m_pending = (m_mode + 1) % 3;
         end
      end
      m_err  = err_n;
      m_vs_d = vs;
      m_de_d = de;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      bit   b;
      b = model_busy();
      e.outs   = {2'(m_mode), m_mode != 0, m_clear, m_clear || (m_warm > 0), m_err, b, !b};
      e.frames = 16'(m_frames);
      return e;
   endfunction

   task automatic step_cycle(input bit vs, de, rv, input logic [1:0] rm, input bit aen, r);
      vs_in = vs; de_in = de; req_valid = rv; req_mode = rm; auto_en = aen; rst = r;
      @(posedge pix_clk);
      model_step(vs, de, rv, int'(rm), aen, r);
      exp_q.push_back(model_out());
      cyc++;
      #1;
   endtask

   task automatic drive_frame(input int lines, input int llen);
      bit         vs, de, rv, r;
      logic [1:0] rm;
      for (int l = 0; l < lines; l++) begin
         for (int c = 0; c < llen; c++) begin
            vs = (l == 0) && (c < 3);
            de = (l >= 1) && (c >= 2) && (c < llen - 1);
            if (rand_edges) begin
               vs = ($urandom_range(3) == 0);
               de = 1'($urandom_range(1));
            end
            rv = ($urandom_range(99) < req_pct);
            rm = 2'($urandom_range(3));
            r  = 0;
            if (shot_mode >= 0 && l == 2 && c == 0) begin
               rv = 1; rm = 2'(shot_mode); shot_mode = -1;
            end
            if (collide && !model_busy() && ae && vs && !m_vs_d && m_frames == FH - 1) begin
               rv = 1; rm = 2'd2; collide = 0;
            end
            if (drop_ae_in_pend && m_pending >= 0 && !m_clear) begin
               ae = 0; drop_ae_in_pend = 0;
            end
            if (rst_g5_shot && m_warm > 0 && m_mode == 2) begin
               r = 1; rst_g5_shot = 0;
            end
            if (rand_rst && $urandom_range(199) == 0) r = 1;
            step_cycle(vs, de, rv, rm, ae, r);
         end
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge pix_clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs{mode,fen,clr,blank,err,busy,rdy}",
                  32'({mode_out, filter_en, lb_clr, out_blank, req_err, busy, req_ready}),
                  32'(e.outs));
            check("frame_cnt", 32'(dut.frame_cnt), 32'(e.frames));
            if (lb_clr === 1'b1) begin
               check("commit_expected", 32'(commit_q.size() > 0), 32'd1);
               if (commit_q.size() > 0) check("commit_mode", 32'(mode_out), 32'(commit_q.pop_front()));
            end
         end
      end
   end

   initial begin : driver
      repeat (2) step_cycle(0, 0, 0, 2'd0, 0, 1);

      // Idle frames, then a mid-frame 3x3 request, then an illegal request.
      repeat (3) drive_frame(6, 10);
      shot_mode = 1;
      repeat (3) drive_frame(6, 10);
      shot_mode = 3;
      repeat (3) drive_frame(6, 10);

      // Auto-cycle, including a manual 5x5 request colliding with an auto event.
      ae = 1;
      repeat (10) drive_frame(6, 10);
      collide = 1;
      repeat (6) drive_frame(6, 10);

      // Reset during 5x5 warm-up, then auto dropped while a change is pending.
      rst_g5_shot = 1;
      repeat (12) drive_frame(6, 10);
      ae = 1;
      drop_ae_in_pend = 1;
      repeat (6) drive_frame(6, 10);

      // Random sync/enable edges, requests and resets.
      rand_edges = 1;
      rand_rst   = 1;
      req_pct    = 5;
      for (int f = 0; f < 40; f++) begin
         ae = 1'($urandom_range(1));
         drive_frame(6, 10);
      end

      rand_edges = 0;
      rand_rst   = 0;
      req_pct    = 0;
      step_cycle(0, 0, 0, 2'd0, 0, 0);
      repeat (2) @(negedge pix_clk);
      #1;
      check("expect_queue_drained", 32'(exp_q.size()), 32'd0);
      check("commit_queue_drained", 32'(commit_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
